// File: rtl/systolic_result_collector.sv
// Deskews the systolic array's y_stream, packs each result row into one word and
// buffers it in a first-word fall-through FIFO. Define SYSTOLIC_COLLECTOR_RELU_EN to clamp negative lanes to 0.
module systolic_result_collector #(
  parameter int data_size  = 4,
  parameter int size       = 3,
  parameter int latency    = 2,
  parameter int fifo_depth = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [data_size*size-1:0] y_stream,
  output logic [data_size*size-1:0] row_data,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic                      row_last,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);

  localparam int W         = data_size * size;
  localparam int PW        = $clog2(fifo_depth);
  localparam int CW        = $clog2(latency + size) + 1;
  localparam int WAIT_LAST = latency + size - 2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  aligned_row;

  // Lane j: one sampling register plus size-1-j delay stages, so every lane of a row
  // reaches the chain end on the edge before its FIFO write.
  for (genvar j = 0; j < size; j++) begin : g_lane
    logic [data_size-1:0] pipe [size-j];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k < size - j; k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= y_stream[(size-j)*data_size-1 -: data_size];
        for (int k = 1; k < size - j; k++) pipe[k] <= pipe[k-1];
      end
    end

`ifdef SYSTOLIC_COLLECTOR_RELU_EN
    assign aligned_row[(size-j)*data_size-1 -: data_size] =
      pipe[size-1-j][data_size-1] ? '0 : pipe[size-1-j];
`else
    assign aligned_row[(size-j)*data_size-1 -: data_size] = pipe[size-1-j];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (cnt == CW'(WAIT_LAST)) begin
            state <= CAPTURE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CAPTURE: begin
          if (cnt == CW'(size - 1)) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

  logic [W:0]    mem [fifo_depth];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          wr_req;
  logic          wr_last;
  logic          wr_en;
  logic          rd_en;
  logic [W:0]    head;

  assign wr_req  = (state == CAPTURE);
  assign wr_last = (cnt == CW'(size - 1));
  assign rd_en   = row_valid && row_ready;
  // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign wr_en   = wr_req && ((count != (PW+1)'(fifo_depth)) || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {wr_last, aligned_row};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (wr_req && !wr_en) overflow <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign row_valid = (count != '0);
  assign row_data  = row_valid ? head[W-1:0] : '0;
  assign row_last  = row_valid ? head[W] : 1'b0;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed self-checking bench for systolic_result_collector (data_size=4, size=3,
// latency=2, fifo_depth=4); honours SYSTOLIC_COLLECTOR_RELU_EN in its expectations.
module tb_systolic_result_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] y_stream;
  logic [11:0] row_data;
  logic        row_valid;
  logic        row_ready;
  logic        row_last;
  logic        busy;
  logic        done;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  logic [12:0] got[$];
  logic [12:0] exp_q[$];

  typedef struct {
    logic        start;
    logic [11:0] y;
    logic        valid;
    logic [11:0] data;
    logic        last;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs [10];

  systolic_result_collector #(
    .data_size(4), .size(3), .latency(2), .fifo_depth(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_stream(y_stream),
    .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
    .row_last(row_last), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Accepted rows: valid && ready seen mid-cycle transfer on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && row_valid && row_ready) got.push_back({row_last, row_data});
  end

  function automatic logic [11:0] relu_row(input logic [11:0] v);
    logic [11:0] r;
    r = v;
`ifdef SYSTOLIC_COLLECTOR_RELU_EN
    for (int j = 0; j < 3; j++) if (r[j*4+3]) r[j*4 +: 4] = 4'h0;
`endif
    return r;
  endfunction

  // Lane j carries 3r+j+1+base for row r on edge 2+r+j (edge 0 = start edge).
  function automatic logic [11:0] gen_y(input int e, input int base);
    logic [11:0] y;
    y = '0;
    for (int j = 0; j < 3; j++) begin
      int r;
      r = e - 2 - j;
      if (r >= 0 && r < 3) y[(3-j)*4-1 -: 4] = 4'((3*r + j + 1 + base) % 16);
    end
    return y;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic rdy, input logic [11:0] y);
    start     = s;
    row_ready = rdy;
    y_stream  = y;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b0, 12'h000);
    rst_n = 1'b1;
    got.delete();
    exp_q.delete();
  endtask

  task automatic compareQueue(input string name);
    checkOutput({name, " count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) checkOutput($sformatf("%s row%0d", name, i), got[i], exp_q[i]);
  endtask

  task automatic pushExp(input logic last, input logic [11:0] v);
    exp_q.push_back({last, relu_row(v)});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; row_ready = 1'b0; y_stream = '0;
    $display("[TB] start");

    doReset();
    checkOutput("reset row_valid", row_valid, 0);
    checkOutput("reset row_data", row_data, 0);
    checkOutput("reset row_last", row_last, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset overflow", overflow, 0);

    // Basic alignment: hand-computed per-edge vectors, row_ready held high.
    vecs[0] = '{1'b1, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 12'h100, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 12'h420, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 12'h753, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 12'h086, 1'b1, 12'h123, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 12'h009, 1'b1, 12'h456, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 12'h000, 1'b1, 12'h789, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    for (int e = 0; e < 10; e++) begin
      applyStimulus(vecs[e].start, 1'b1, vecs[e].y);
      checkOutput($sformatf("basic e%0d row_valid", e), row_valid, vecs[e].valid);
      checkOutput($sformatf("basic e%0d row_data", e), row_data, vecs[e].data);
      checkOutput($sformatf("basic e%0d row_last", e), row_last, vecs[e].last);
      checkOutput($sformatf("basic e%0d busy", e), busy, vecs[e].busy);
      checkOutput($sformatf("basic e%0d done", e), done, vecs[e].done);
    end
    pushExp(1'b0, 12'h123); pushExp(1'b0, 12'h456); pushExp(1'b1, 12'h789);
    compareQueue("basic");
    checkOutput("basic overflow", overflow, 0);

    // Backpressure: row_ready low until edge 12.
    doReset();
    for (int e = 0; e < 17; e++) begin
      applyStimulus(e == 0, e >= 12, gen_y(e, 0));
      if (e >= 5 && e <= 11) begin
        checkOutput($sformatf("bp e%0d row_valid", e), row_valid, 1);
        checkOutput($sformatf("bp e%0d row_data", e), row_data, 12'h123);
      end
    end
    checkOutput("bp drained row_valid", row_valid, 0);
    checkOutput("bp overflow", overflow, 0);
    pushExp(1'b0, 12'h123); pushExp(1'b0, 12'h456); pushExp(1'b1, 12'h789);
    compareQueue("bp");

    // Overflow: two back-to-back matrices, second start coincident with done.
    doReset();
    for (int e = 0; e < 18; e++) begin
      applyStimulus(e == 0 || e == 8, 1'b0, gen_y(e, 0) | gen_y(e - 8, 8));
      if (e == 7) checkOutput("ovf done e7", done, 1);
      if (e == 8) checkOutput("ovf busy e8", busy, 1);
      if (e == 13) checkOutput("ovf e13 overflow", overflow, 0);
    end
    checkOutput("ovf overflow", overflow, 1);
    checkOutput("ovf head", row_data, relu_row(12'h123));
    for (int e = 0; e < 6; e++) applyStimulus(1'b0, 1'b1, 12'h000);
    pushExp(1'b0, 12'h123); pushExp(1'b0, 12'h456); pushExp(1'b1, 12'h789);
    pushExp(1'b0, 12'h9ab);
    compareQueue("ovf");
    checkOutput("ovf sticky", overflow, 1);
    checkOutput("ovf empty", row_valid, 0);

    // Ignored start during WAIT, then reset mid-capture (with a coincident start).
    doReset();
    for (int e = 0; e < 6; e++) applyStimulus(e == 0 || e == 3, 1'b1, gen_y(e, 0));
    checkOutput("ign e5 row_valid", row_valid, 1);
    checkOutput("ign e5 row_data", row_data, 12'h123);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 12'h000);
    checkOutput("midrst row_valid", row_valid, 0);
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst row_data", row_data, 0);
    checkOutput("midrst done", done, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 12'h000);
    checkOutput("midrst busy after", busy, 0);
    checkOutput("midrst valid after", row_valid, 0);
    got.delete();
    for (int e = 0; e < 10; e++) applyStimulus(e == 0, 1'b1, gen_y(e, 0));
    pushExp(1'b0, 12'h123); pushExp(1'b0, 12'h456); pushExp(1'b1, 12'h789);
    compareQueue("fresh");

    // Full FIFO with a read on the same edge as a write.
    doReset();
    for (int e = 0; e < 23; e++) begin
      applyStimulus(e == 0 || e == 8, e >= 14, gen_y(e, 0) | gen_y(e - 8, 8));
      if (e == 13) checkOutput("simul e13 row_data", row_data, relu_row(12'h123));
    end
    checkOutput("simul overflow", overflow, 0);
    checkOutput("simul empty", row_valid, 0);
    pushExp(1'b0, 12'h123); pushExp(1'b0, 12'h456); pushExp(1'b1, 12'h789);
    pushExp(1'b0, 12'h9ab); pushExp(1'b0, 12'hcde); pushExp(1'b1, 12'hf01);
    compareQueue("simul");

    // Negative lanes in row 0: 9, 2, F.
    doReset();
    for (int e = 0; e < 10; e++) begin
      logic [11:0] y;
      y = (e == 2) ? 12'h900 : (e == 3) ? 12'h020 : (e == 4) ? 12'h00F : 12'h000;
      applyStimulus(e == 0, 1'b1, y);
    end
`ifdef SYSTOLIC_COLLECTOR_RELU_EN
    exp_q.push_back({1'b0, 12'h020});
`else
    exp_q.push_back({1'b0, 12'h92F});
`endif
    exp_q.push_back({1'b0, 12'h000});
    exp_q.push_back({1'b1, 12'h000});
    compareQueue("relu");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
